// File: rtl/morse_pkg.sv
// morse_pkg: shared FSM states, Morse unit lengths and the ASCII-to-Morse lookup
package morse_pkg;

    typedef enum logic [2:0] {IDLE, MARK, SYM_GAP, CHAR_GAP, WORD_GAP} state_t;

    typedef struct packed {
        logic       valid;
        logic       is_space;
        logic [2:0] len;
        logic [4:0] pat;
    } morse_code_t;

    localparam logic [2:0] DOT_U      = 3'd1;
    localparam logic [2:0] DASH_U     = 3'd3;
    localparam logic [2:0] SYM_GAP_U  = 3'd1;
    localparam logic [2:0] CHAR_GAP_U = 3'd3;
    localparam logic [2:0] WORD_GAP_U = 3'd4;

    // pat is MSB-first and left-aligned; 1 = dash
    function automatic morse_code_t morse_lookup(input logic [7:0] c);
        logic [7:0]  u;
        logic [3:0]  d;
        morse_code_t r;
        r = '0;
        u = (c >= "a" && c <= "z") ? c - 8'd32 : c;
        d = 4'(u - "0");
        if (u == " ") begin
            r.valid    = 1'b1;
            r.is_space = 1'b1;
        end else if (u >= "0" && u <= "9") begin
            r.valid = 1'b1;
            r.len   = 3'd5;
            r.pat   = (d <= 4'd5) ? 5'b11111 >> d : 5'b11111 << (4'd10 - d);
        end else if (u >= "A" && u <= "Z") begin
            r.valid = 1'b1;
            case (u)
                "A": {r.len, r.pat} = {3'd2, 5'b01000};
                "B": {r.len, r.pat} = {3'd4, 5'b10000};
                "C": {r.len, r.pat} = {3'd4, 5'b10100};
                "D": {r.len, r.pat} = {3'd3, 5'b10000};
                "E": {r.len, r.pat} = {3'd1, 5'b00000};
                "F": {r.len, r.pat} = {3'd4, 5'b00100};
                "G": {r.len, r.pat} = {3'd3, 5'b11000};
                "H": {r.len, r.pat} = {3'd4, 5'b00000};
                "I": {r.len, r.pat} = {3'd2, 5'b00000};
                "J": {r.len, r.pat} = {3'd4, 5'b01110};
                "K": {r.len, r.pat} = {3'd3, 5'b10100};
                "L": {r.len, r.pat} = {3'd4, 5'b01000};
                "M": {r.len, r.pat} = {3'd2, 5'b11000};
                "N": {r.len, r.pat} = {3'd2, 5'b10000};
                "O": {r.len, r.pat} = {3'd3, 5'b11100};
                "P": {r.len, r.pat} = {3'd4, 5'b01100};
                "Q": {r.len, r.pat} = {3'd4, 5'b11010};
                "R": {r.len, r.pat} = {3'd3, 5'b01000};
                "S": {r.len, r.pat} = {3'd3, 5'b00000};
                "T": {r.len, r.pat} = {3'd1, 5'b10000};
                "U": {r.len, r.pat} = {3'd3, 5'b00100};
                "V": {r.len, r.pat} = {3'd4, 5'b00010};
                "W": {r.len, r.pat} = {3'd3, 5'b01100};
                "X": {r.len, r.pat} = {3'd4, 5'b10010};
                "Y": {r.len, r.pat} = {3'd4, 5'b10110};
                "Z": {r.len, r.pat} = {3'd4, 5'b11000};
                default: r.valid = 1'b0;
            endcase
        end
        return r;
    endfunction

endpackage

// File: rtl/morse_tx_tone.sv
// morse_tone_gen: square-wave tone divider; each mark starts on a high phase
module morse_tone_gen #(
    parameter int TONE_HALF = 12500
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_enable,
    input  logic i_restart,
    output logic o_sound
);

    localparam int DW = $clog2(TONE_HALF + 1);

    logic [DW-1:0] r_div;
    logic          r_phase;
    logic          r_sound;
    logic          w_wrap;

    assign w_wrap  = r_div == DW'(TONE_HALF - 1);
    assign o_sound = r_sound;

    // divider and phase; the sound register leads by one cycle so it lines up with the key
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_div   <= '0;
            r_phase <= 1'b0;
            r_sound <= 1'b0;
        end else if (i_restart) begin
            r_div   <= '0;
            r_phase <= 1'b1;
            r_sound <= 1'b1;
        end else if (!i_enable) begin
            r_div   <= '0;
            r_sound <= 1'b0;
        end else begin
            r_div   <= w_wrap ? '0 : r_div + 1'b1;
            r_phase <= r_phase ^ w_wrap;
            r_sound <= r_phase ^ w_wrap;
        end
    end

endmodule

// File: rtl/morse_tx.sv
// morse_tx: ASCII-to-Morse keyer with tone output; MORSE_TX_FIFO_EN adds an input queue
module morse_tx
    import morse_pkg::*;
#(
    parameter int UNIT_CYCLES = 1200000,
    parameter int TONE_HALF   = 12500,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic       iCLK,
    input  logic       iRST,
    input  logic [7:0] iDATA,
    input  logic       iVALID,
    output logic       oREADY,
    output logic       oKEY,
    output logic       oSOUND,
    output logic       oBUSY
);

    localparam int CW = $clog2(UNIT_CYCLES + 1);

    state_t        r_state, w_next;
    logic [CW-1:0] r_cyc;
    logic [2:0]    r_units, r_left, w_load_units;
    logic [4:0]    r_pat;
    logic          r_key;
    logic          w_done, w_take, w_load;
    logic [7:0]    w_char;
    morse_code_t   w_code;

`ifdef MORSE_TX_FIFO_EN
    localparam int AW = $clog2(FIFO_DEPTH);

    logic [7:0] r_mem [FIFO_DEPTH];
    logic [AW:0] r_wp, r_rp;
    logic        w_empty, w_full;

    assign w_empty = r_wp == r_rp;
    assign w_full  = (r_wp ^ r_rp) == {1'b1, {AW{1'b0}}};
    assign w_take  = (r_state == IDLE) && !w_empty;
    assign oREADY  = !w_full || w_take;
    assign w_char  = r_mem[r_rp[AW-1:0]];
    assign oBUSY   = (r_state != IDLE) || !w_empty;

    // queue pointers and storage; a pop frees a slot for a same-cycle push
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            r_wp <= '0;
            r_rp <= '0;
        end else begin
            if (iVALID && oREADY) begin
                r_mem[r_wp[AW-1:0]] <= iDATA;
                r_wp                <= r_wp + 1'b1;
            end
            if (w_take) r_rp <= r_rp + 1'b1;
        end
    end
`else
    assign oREADY = r_state == IDLE;
    assign w_take = iVALID && oREADY;
    assign w_char = iDATA;
    assign oBUSY  = r_state != IDLE;
`endif

    assign w_code = morse_lookup(w_char);
    assign w_done = (r_cyc == CW'(UNIT_CYCLES - 1)) && (r_units == 3'd0);
    assign oKEY   = r_key;

    // next state and the unit length loaded on entering a timed state
    always_comb begin
        w_next       = r_state;
        w_load       = 1'b0;
        w_load_units = 3'd0;
        case (r_state)
            IDLE: if (w_take && w_code.valid) begin
                w_load       = 1'b1;
                w_next       = w_code.is_space ? WORD_GAP : MARK;
                w_load_units = w_code.is_space ? WORD_GAP_U : (w_code.pat[4] ? DASH_U : DOT_U);
            end
            MARK: if (w_done) begin
                w_load       = 1'b1;
                w_next       = (r_left != 3'd0) ? SYM_GAP : CHAR_GAP;
                w_load_units = (r_left != 3'd0) ? SYM_GAP_U : CHAR_GAP_U;
            end
            SYM_GAP: if (w_done) begin
                w_load       = 1'b1;
                w_next       = MARK;
                w_load_units = r_pat[4] ? DASH_U : DOT_U;
            end
            CHAR_GAP, WORD_GAP: if (w_done) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // state, unit timing and remaining-symbol tracking
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            r_state <= IDLE;
            r_cyc   <= '0;
            r_units <= 3'd0;
            r_left  <= 3'd0;
            r_pat   <= 5'd0;
            r_key   <= 1'b0;
        end else begin
            r_state <= w_next;
            r_key   <= w_next == MARK;
            if (w_load) begin
                r_cyc   <= '0;
                r_units <= w_load_units - 3'd1;
            end else if (w_done) begin
                r_cyc   <= '0;
                r_units <= 3'd0;
            end else if (r_state != IDLE) begin
                r_cyc   <= (r_cyc == CW'(UNIT_CYCLES - 1)) ? '0 : r_cyc + 1'b1;
                r_units <= (r_cyc == CW'(UNIT_CYCLES - 1)) ? r_units - 3'd1 : r_units;
            end
            if (r_state == IDLE && w_load && !w_code.is_space) begin
                r_pat  <= {w_code.pat[3:0], 1'b0};
                r_left <= w_code.len - 3'd1;
            end else if (r_state == SYM_GAP && w_done) begin
                r_pat  <= {r_pat[3:0], 1'b0};
                r_left <= r_left - 3'd1;
            end
        end
    end

    morse_tone_gen #(.TONE_HALF(TONE_HALF)) u_tone (
        .i_clk     (iCLK),
        .i_rst     (iRST),
        .i_enable  (w_next == MARK),
        .i_restart (w_load && w_next == MARK),
        .o_sound   (oSOUND)
    );

endmodule

// File: tb/tb_morse_tx.sv
// tb_morse_tx: directed checks of morse_tx keying, tone, handshake and reset
module tb_morse_tx;

    logic       iCLK = 1'b0;
    logic       iRST = 1'b1;
    logic [7:0] iDATA = 8'd0;
    logic       iVALID = 1'b0;
    logic       oREADY, oKEY, oSOUND, oBUSY;

    int checks = 0;
    int failures = 0;

    logic [127:0] kv, sv, rv, bv, ek, es;

    morse_tx #(.UNIT_CYCLES(4), .TONE_HALF(1), .FIFO_DEPTH(4)) dut (
        .iCLK   (iCLK),
        .iRST   (iRST),
        .iDATA  (iDATA),
        .iVALID (iVALID),
        .oREADY (oREADY),
        .oKEY   (oKEY),
        .oSOUND (oSOUND),
        .oBUSY  (oBUSY)
    );

    always #5 iCLK = ~iCLK;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // drive one character so that the following posedge is the accepting edge T
    task automatic send(input logic [7:0] c);
        @(negedge iCLK);
        iDATA  = c;
        iVALID = 1'b1;
        @(posedge iCLK);
        #1 iVALID = 1'b0;
        iDATA = 8'hxx;
    endtask

    // record outputs for cycles T+1..T+n at bit index k
    task automatic capture(input int n);
        kv = '0; sv = '0; rv = '0; bv = '0;
        for (int k = 1; k <= n; k++) begin
            @(negedge iCLK);
            kv[k] = oKEY;
            sv[k] = oSOUND;
            rv[k] = oREADY;
            bv[k] = oBUSY;
        end
    endtask

    initial begin
        repeat (2) @(posedge iCLK);
        @(negedge iCLK);
        check("rst_key", 128'(oKEY), 128'd0);
        check("rst_sound", 128'(oSOUND), 128'd0);
        check("rst_busy", 128'(oBUSY), 128'd0);
        check("rst_ready", 128'(oREADY), 128'd1);
        iRST = 1'b0;

        send("E");
        capture(20);
        check("E_key", kv, 128'h1E);
        check("E_sound", sv, 128'hA);
        check("E_ready16", 128'(rv[16]), 128'd0);
        check("E_ready17", 128'(rv[17]), 128'd1);
        check("E_busy17", 128'(bv[17]), 128'd0);

        send("a");
        capture(34);
        check("a_key", kv, 128'h1FFE1E);
        check("a_sound", sv, 128'hAAA0A);
        check("a_ready32", 128'(rv[32]), 128'd0);
        check("a_ready33", 128'(rv[33]), 128'd1);

        send("0");
        capture(92);
        ek = '0; es = '0;
        for (int m = 0; m < 5; m++)
            for (int j = 0; j < 12; j++) begin
                ek[1 + m*16 + j] = 1'b1;
                es[1 + m*16 + j] = (j % 2) == 0;
            end
        check("zero_key", kv, ek);
        check("zero_sound", sv, es);
        check("zero_busy88", 128'(bv[88]), 128'd1);
        check("zero_busy89", 128'(bv[89]), 128'd0);
        check("zero_ready88", 128'(rv[88]), 128'd0);
        check("zero_ready89", 128'(rv[89]), 128'd1);

        send(" ");
        capture(18);
        check("space_key", kv, 128'd0);
        check("space_busy16", 128'(bv[16]), 128'd1);
        check("space_ready16", 128'(rv[16]), 128'd0);
        check("space_ready17", 128'(rv[17]), 128'd1);

        send("#");
        capture(4);
        check("hash_ready", rv, 128'h1E);
        check("hash_busy", bv, 128'd0);
        check("hash_key", kv, 128'd0);

        send("T");
        capture(5);
        check("T_key_on", kv, 128'h3E);
        @(negedge iCLK);
        iRST = 1'b1;
        @(negedge iCLK);
        check("mrst_key", 128'(oKEY), 128'd0);
        check("mrst_sound", 128'(oSOUND), 128'd0);
        check("mrst_ready", 128'(oREADY), 128'd1);
        check("mrst_busy", 128'(oBUSY), 128'd0);
        iRST = 1'b0;

        send("E");
        capture(20);
        check("E2_key", kv, 128'h1E);
        check("E2_sound", sv, 128'hA);
        check("E2_ready17", 128'(rv[17]), 128'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
